// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receive and transmit FIFOs.
//
// Contents:
//   UART_DATA_W                  character width in bits
//   UART_FIFO_DEPTH_DEFAULT      default FIFO depth (entries)
//   UART_FIFO_THRESHOLD_DEFAULT  default fill level for the interrupt
//   rx_entry_t                   one stored receive character
//   RX_ENTRY_W                   width of rx_entry_t in bits
//
// Optional feature macro: UART_RX_FIFO_PARITY_EN
//   When this macro is defined, each entry also carries the parity status.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W                 = 8;
    localparam int UART_FIFO_DEPTH_DEFAULT     = 16;
    localparam int UART_FIFO_THRESHOLD_DEFAULT = 8;

    // The parity status is stored as an error flag rather than an ok flag.
    // A cleared read register then reads as "no error", which is the value
    // the CPU should see out of reset.
    typedef struct packed {
`ifdef UART_RX_FIFO_PARITY_EN
        logic                   perr;
`endif
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port storage for the UART FIFOs. Writes are synchronous. The
// read data is registered and holds its value when no read is requested.
//
// Parameters:
//   WIDTH    entry width in bits
//   DEPTH    number of entries (power of two)
// Ports:
//   sys_clk  system clock (rising edge)
//   reset    synchronous active-high; clears only the read register
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read enable; loads rd_data from rd_addr
//   rd_addr  read address
//   rd_data  registered read data
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The storage array has no reset. The FIFO control logic never reads an
    // entry before that entry has been written.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register samples the old contents of the array. A full FIFO
    // that pushes and pops in the same cycle therefore returns the oldest
    // entry, even though the write targets the same slot.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer between the UART receiver and the CPU register interface.
// The block captures one character on each rising edge of rx_ready and
// acknowledges it. Characters are stored in a circular FIFO and handed to
// the CPU one per rd_req.
//
// Parameters:
//   DEPTH         entries (power of two, 4..256)
//   THRESHOLD     irq asserts when count >= THRESHOLD (1..DEPTH)
// Ports:
//   sys_clk       system clock (rising edge)
//   reset         synchronous active-high reset
//   rx_ready      receiver data-ready level (synchronous)
//   rx_data       received character
//   rx_parity_ok  receiver parity result (1 = ok)
//   rx_ack        one-cycle pulse back to the receiver's data_read
//   rd_req        CPU read strobe
//   rd_data       last popped character
//   rd_perr       parity error flag of the last popped character
//   rd_valid      one-cycle pulse: rd_data/rd_perr were updated
//   count         current occupancy
//   empty, full   occupancy flags
//   overrun       sticky: a character was dropped
//   clr_overrun   clears overrun (a simultaneous drop wins)
//   irq           registered threshold interrupt
//
// Optional feature macro: UART_RX_FIFO_PARITY_EN
//   Defined:   the parity status is stored and returned on rd_perr.
//   Undefined: rx_parity_ok is ignored and rd_perr is held at 0.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_FIFO_DEPTH_DEFAULT,
    parameter int THRESHOLD = UART_FIFO_THRESHOLD_DEFAULT
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   rx_ready,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_parity_ok,
    output logic                   rx_ack,
    input  logic                   rd_req,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_perr,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overrun,
    input  logic                   clr_overrun,
    output logic                   irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_ready_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_det;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [CW-1:0] count_next;
    rx_entry_t     wr_entry;
    rx_entry_t     rd_entry;

    // A full FIFO can still accept a push when a pop in the same cycle frees
    // a slot. An empty FIFO ignores the pop, and the push still proceeds.
    assign push_det = rx_ready & ~rx_ready_q;
    assign pop      = rd_req & ~empty;
    assign push_ok  = push_det & (~full | pop);
    assign drop     = push_det & full & ~pop;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    // The occupancy counter moves only when exactly one of push or pop
    // takes effect.
    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Control state: edge detector, pointers, counter and response pulses.
    // The irq register samples the count register, so it lags count by
    // one cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_ready_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            rx_ack     <= push_det;
            rd_valid   <= pop;
            count      <= count_next;
            irq        <= (count >= CW'(THRESHOLD));
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Sticky overrun flag. If a drop and a clear occur in the same cycle,
    // the drop takes priority so that the lost character is still reported.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Build the entry to store. Without the parity feature, the entry holds
    // only the character.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = rx_data;
`ifdef UART_RX_FIFO_PARITY_EN
        wr_entry.perr = ~rx_parity_ok;
`endif
    end

    assign rd_data = rd_entry.data;

`ifdef UART_RX_FIFO_PARITY_EN
    assign rd_perr = rd_entry.perr;
`else
    logic parity_unused;
    assign parity_unused = rx_parity_ok;
    assign rd_perr       = 1'b0;
`endif

    uart_fifo_mem #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .sys_clk (sys_clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

endmodule
